// File: rtl/uart_cfg_core.sv
// Configurable UART transceiver: shared oversampling baud tick, TX and RX frame FSMs,
// optional internal loopback of txd into the receiver.
module uart_cfg_core #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 txd,
    input  logic                 rxd,
    input  logic                 loopback,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);
    localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = $clog2(DIV + 1);
    localparam int unsigned OS_W    = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W   = 3;
    localparam logic        PAR_EN  = (PARITY_EN != 0);
    localparam logic        PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // Free-running baud tick shared by both directions
    logic [DIV_W-1:0] div_q;
    logic             tick;
    assign tick = (div_q == DIV_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)    div_q <= '0;
        else if (tick) div_q <= '0;
        else           div_q <= div_q + DIV_W'(1);
    end

    // ---------------- transmitter ----------------
    state_t               tx_state_q, tx_state_d;
    logic [OS_W-1:0]      tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shr_q, tx_shr_d;
    logic                 tx_par_q, tx_par_d;
    logic                 txd_q, txd_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_done_q, tx_done_d;
    logic                 tx_bit_end;

    assign tx_bit_end = tick && (tx_cnt_q == OS_W'(OVERSAMPLE - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shr_q   <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shr_q   <= tx_shr_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    // txd_d is the line level for the state being entered, so txd is glitch-free
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shr_d   = tx_shr_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        tx_busy_d  = tx_busy_q;
        tx_done_d  = 1'b0;
        if (tx_state_q != S_IDLE && tick)
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + OS_W'(1);
        case (tx_state_q)
            S_IDLE: begin
                txd_d     = 1'b1;
                tx_busy_d = 1'b0;
                if (tx_start) begin
                    tx_state_d = S_START;
                    tx_cnt_d   = '0;
                    tx_shr_d   = tx_data;
                    tx_par_d   = (^tx_data) ^ PAR_ODD;
                    txd_d      = 1'b0;
                    tx_busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (tx_bit_end) begin
                    tx_state_d = S_DATA;
                    tx_bit_d   = '0;
                    txd_d      = tx_shr_q[0];
                end
            end
            S_DATA: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == BIT_W'(DATA_BITS - 1)) begin
                        tx_bit_d = '0;
                        if (PAR_EN) begin
                            tx_state_d = S_PARITY;
                            txd_d      = tx_par_q;
                        end else begin
                            tx_state_d = S_STOP;
                            txd_d      = 1'b1;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_W'(1);
                        tx_shr_d = tx_shr_q >> 1;
                        txd_d    = tx_shr_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d = S_STOP;
                    tx_bit_d   = '0;
                    txd_d      = 1'b1;
                end
            end
            S_STOP: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == BIT_W'(STOP_BITS - 1)) begin
                        tx_state_d = S_IDLE;
                        tx_done_d  = 1'b1;
                        tx_busy_d  = 1'b0;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_W'(1);
                    end
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    assign txd     = txd_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;

    // ---------------- receiver ----------------
    logic rxd_s1_q, rxd_s2_q, rx_line;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxd_s1_q <= 1'b1;
            rxd_s2_q <= 1'b1;
        end else begin
            rxd_s1_q <= rxd;
            rxd_s2_q <= rxd_s1_q;
        end
    end

    assign rx_line = loopback ? txd_q : rxd_s2_q;

    state_t               rx_state_q, rx_state_d;
    logic [OS_W-1:0]      rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shr_q, rx_shr_d;
    logic                 rx_perr_q, rx_perr_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_done_q, rx_done_d;
    logic                 rx_perr_o_q, rx_perr_o_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_full, rx_half;

    assign rx_full = (rx_cnt_q == OS_W'(OVERSAMPLE - 1));
    assign rx_half = (rx_cnt_q == OS_W'(OVERSAMPLE / 2 - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q  <= S_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shr_q    <= '0;
            rx_perr_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            rx_perr_o_q <= 1'b0;
            rx_ferr_q   <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shr_q    <= rx_shr_d;
            rx_perr_q   <= rx_perr_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            rx_perr_o_q <= rx_perr_o_d;
            rx_ferr_q   <= rx_ferr_d;
        end
    end

    // Start is qualified at half a bit; every later sample lands mid-bit
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shr_d    = rx_shr_q;
        rx_perr_d   = rx_perr_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        rx_perr_o_d = rx_perr_o_q;
        rx_ferr_d   = rx_ferr_q;
        if (rx_state_q != S_IDLE && rx_state_q != S_START && tick)
            rx_cnt_d = rx_full ? '0 : rx_cnt_q + OS_W'(1);
        case (rx_state_q)
            S_IDLE: begin
                if (tick && !rx_line) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rx_half) begin
                        rx_cnt_d   = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rx_line ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt_d = rx_cnt_q + OS_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (tick && rx_full) begin
                    rx_shr_d = {rx_line, rx_shr_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BIT_W'(DATA_BITS - 1))
                        rx_state_d = PAR_EN ? S_PARITY : S_STOP;
                    else
                        rx_bit_d = rx_bit_q + BIT_W'(1);
                end
            end
            S_PARITY: begin
                if (tick && rx_full) begin
                    rx_perr_d  = rx_line ^ (^rx_shr_q) ^ PAR_ODD;
                    rx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick && rx_full) begin
                    rx_state_d  = S_IDLE;
                    rx_done_d   = 1'b1;
                    rx_data_d   = rx_shr_q;
                    rx_perr_o_d = PAR_EN && rx_perr_q;
                    rx_ferr_d   = !rx_line;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    assign rx_data       = rx_data_q;
    assign rx_done       = rx_done_q;
    assign rx_parity_err = rx_perr_o_q;
    assign rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_cfg_core.sv
// Scoreboard bench for uart_cfg_core: 8N1, 8E1 and 7N2 instances at 16 clk per bit.
`timescale 1ns/1ps
module tb_uart_cfg_core;
    localparam int unsigned CLKF = 1600000;
    localparam int unsigned BAUD = 100000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // instance a: 8N1, b: 8 data even parity, c: 7 data two stop bits
    logic       tx_start_a, tx_start_b, tx_start_c;
    logic [7:0] tx_data_a, tx_data_b;
    logic [6:0] tx_data_c;
    logic       tx_busy_a, tx_busy_b, tx_busy_c;
    logic       tx_done_a, tx_done_b, tx_done_c;
    logic       txd_a, txd_b, txd_c;
    logic       rxd_a, rxd_b, rxd_c;
    logic       loopback_a, loopback_b, loopback_c;
    logic [7:0] rx_data_a, rx_data_b;
    logic [6:0] rx_data_c;
    logic       rx_done_a, rx_done_b, rx_done_c;
    logic       rx_perr_a, rx_perr_b, rx_perr_c;
    logic       rx_ferr_a, rx_ferr_b, rx_ferr_c;

    uart_cfg_core #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .OVERSAMPLE(16), .DATA_BITS(8),
                    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start_a), .tx_data(tx_data_a),
        .tx_busy(tx_busy_a), .tx_done(tx_done_a), .txd(txd_a), .rxd(rxd_a),
        .loopback(loopback_a), .rx_data(rx_data_a), .rx_done(rx_done_a),
        .rx_parity_err(rx_perr_a), .rx_frame_err(rx_ferr_a));

    uart_cfg_core #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .OVERSAMPLE(16), .DATA_BITS(8),
                    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start_b), .tx_data(tx_data_b),
        .tx_busy(tx_busy_b), .tx_done(tx_done_b), .txd(txd_b), .rxd(rxd_b),
        .loopback(loopback_b), .rx_data(rx_data_b), .rx_done(rx_done_b),
        .rx_parity_err(rx_perr_b), .rx_frame_err(rx_ferr_b));

    uart_cfg_core #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .OVERSAMPLE(16), .DATA_BITS(7),
                    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_c (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start_c), .tx_data(tx_data_c),
        .tx_busy(tx_busy_c), .tx_done(tx_done_c), .txd(txd_c), .rxd(rxd_c),
        .loopback(loopback_c), .rx_data(rx_data_c), .rx_done(rx_done_c),
        .rx_parity_err(rx_perr_c), .rx_frame_err(rx_ferr_c));

    // Scoreboard: rx words are {parity_err, frame_err, data}; tx entries are busy lengths
    logic [9:0] exp_rx_a[$], exp_rx_b[$], exp_rx_c[$];
    int         exp_tx_a[$], exp_tx_b[$], exp_tx_c[$];
    int pushed_rx_a = 0, pushed_rx_b = 0, pushed_rx_c = 0;
    int pushed_tx_a = 0, pushed_tx_b = 0, pushed_tx_c = 0;
    int seen_rx_a = 0, seen_rx_b = 0, seen_rx_c = 0;
    int seen_tx_a = 0, seen_tx_b = 0, seen_tx_c = 0;
    int run_a = 0, run_b = 0, run_c = 0;
    int rx_cyc_a = 0, tx_cyc_a = 0, rx_cyc_c = 0, tx_cyc_c = 0;

    always @(negedge clk) begin
        if (rx_done_a) begin
            seen_rx_a++; rx_cyc_a = cyc;
            if (exp_rx_a.size() > 0)
                check("rx_a", {22'd0, rx_perr_a, rx_ferr_a, rx_data_a}, {22'd0, exp_rx_a.pop_front()});
        end
        if (tx_done_a) begin
            seen_tx_a++; tx_cyc_a = cyc;
            if (exp_tx_a.size() > 0) check("tx_a_busy_len", run_a, exp_tx_a.pop_front());
        end
        run_a = tx_busy_a ? run_a + 1 : 0;
    end

    always @(negedge clk) begin
        if (rx_done_b) begin
            seen_rx_b++;
            if (exp_rx_b.size() > 0)
                check("rx_b", {22'd0, rx_perr_b, rx_ferr_b, rx_data_b}, {22'd0, exp_rx_b.pop_front()});
        end
        if (tx_done_b) begin
            seen_tx_b++;
            if (exp_tx_b.size() > 0) check("tx_b_busy_len", run_b, exp_tx_b.pop_front());
        end
        run_b = tx_busy_b ? run_b + 1 : 0;
    end

    always @(negedge clk) begin
        if (rx_done_c) begin
            seen_rx_c++; rx_cyc_c = cyc;
            if (exp_rx_c.size() > 0)
                check("rx_c", {22'd0, rx_perr_c, rx_ferr_c, 1'b0, rx_data_c}, {22'd0, exp_rx_c.pop_front()});
        end
        if (tx_done_c) begin
            seen_tx_c++; tx_cyc_c = cyc;
            if (exp_tx_c.size() > 0) check("tx_c_busy_len", run_c, exp_tx_c.pop_front());
        end
        run_c = tx_busy_c ? run_c + 1 : 0;
    end

    task automatic set_rxd(input int sel, input logic v);
        case (sel)
            0:       rxd_a = v;
            1:       rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    // Drive one 8-bit frame on an external rxd; par < 0 means no parity bit
    task automatic send_rx(input int sel, input logic [7:0] d, input int par, input logic stop_v);
        set_rxd(sel, 1'b0);
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rxd(sel, d[i]);
            repeat (16) @(negedge clk);
        end
        if (par >= 0) begin
            set_rxd(sel, par[0]);
            repeat (16) @(negedge clk);
        end
        set_rxd(sel, stop_v);
        repeat (16) @(negedge clk);
        set_rxd(sel, 1'b1);
        repeat (40) @(negedge clk);
    endtask

    logic [9:0] fbits;
    int         before_tx, before_rx, k;

    initial begin
        rst_n = 1'b0;
        tx_start_a = 1'b0; tx_start_b = 1'b0; tx_start_c = 1'b0;
        tx_data_a = '0; tx_data_b = '0; tx_data_c = '0;
        rxd_a = 1'b1; rxd_b = 1'b1; rxd_c = 1'b1;
        loopback_a = 1'b1; loopback_b = 1'b1; loopback_c = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_a", {txd_a, tx_busy_a, tx_done_a, rx_done_a, rx_perr_a, rx_ferr_a, rx_data_a}, 14'h2000);
        check("reset_b", {txd_b, tx_busy_b, tx_done_b, rx_done_b, rx_perr_b, rx_ferr_b, rx_data_b}, 14'h2000);
        check("reset_c", {txd_c, tx_busy_c, tx_done_c, rx_done_c, rx_perr_c, rx_ferr_c, rx_data_c}, 13'h1000);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Test 1: 8N1 loopback 0xA5, txd sampled mid-bit
        exp_rx_a.push_back(10'h0A5); pushed_rx_a++;
        exp_tx_a.push_back(160);     pushed_tx_a++;
        tx_data_a = 8'hA5; tx_start_a = 1'b1;
        @(negedge clk); tx_start_a = 1'b0;
        fbits = {1'b1, 8'hA5, 1'b0};
        repeat (7) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t1_txd_bit%0d", i), txd_a, fbits[i]);
            repeat (16) @(negedge clk);
        end
        repeat (40) @(negedge clk);
        // rx_done follows the mid-stop-bit sample; tx_done ends the stop bit
        check("t1_done_gap", tx_cyc_a - rx_cyc_a, 7);

        // Test 2: even parity, loopback then a bad-parity external frame
        exp_rx_b.push_back(10'h007); pushed_rx_b++;
        exp_tx_b.push_back(176);     pushed_tx_b++;
        tx_data_b = 8'h07; tx_start_b = 1'b1;
        @(negedge clk); tx_start_b = 1'b0;
        repeat (7 + 16 * 9) @(negedge clk);
        check("t2_parity_bit", txd_b, 1'b1);
        repeat (60) @(negedge clk);
        loopback_b = 1'b0;
        exp_rx_b.push_back(10'h207); pushed_rx_b++;
        send_rx(1, 8'h07, 0, 1'b1);

        // Test 3: frame error then a clean frame
        loopback_a = 1'b0;
        exp_rx_a.push_back(10'h13C); pushed_rx_a++;
        send_rx(0, 8'h3C, -1, 1'b0);
        exp_rx_a.push_back(10'h055); pushed_rx_a++;
        send_rx(0, 8'h55, -1, 1'b1);

        // Test 4: 4-clk glitch is rejected, following frame is received
        before_rx = seen_rx_a;
        rxd_a = 1'b0;
        repeat (4) @(negedge clk);
        rxd_a = 1'b1;
        repeat (40) @(negedge clk);
        check("t4_false_start", seen_rx_a - before_rx, 0);
        exp_rx_a.push_back(10'h081); pushed_rx_a++;
        send_rx(0, 8'h81, -1, 1'b1);

        // Test 5a: tx_start during a frame is ignored
        loopback_a = 1'b1;
        before_tx = seen_tx_a;
        exp_rx_a.push_back(10'h011); pushed_rx_a++;
        exp_tx_a.push_back(160);     pushed_tx_a++;
        tx_data_a = 8'h11; tx_start_a = 1'b1;
        @(negedge clk); tx_start_a = 1'b0;
        repeat (40) @(negedge clk);
        tx_data_a = 8'hEE; tx_start_a = 1'b1;
        @(negedge clk); tx_start_a = 1'b0;
        repeat (200) @(negedge clk);
        check("t5_ignored_start", seen_tx_a - before_tx, 1);

        // Test 5b: held tx_start gives two back-to-back frames
        before_tx = seen_tx_a;
        exp_rx_a.push_back(10'h03C); exp_rx_a.push_back(10'h0C3); pushed_rx_a += 2;
        exp_tx_a.push_back(160);     exp_tx_a.push_back(160);     pushed_tx_a += 2;
        tx_data_a = 8'h3C; tx_start_a = 1'b1;
        @(negedge clk);
        for (k = 0; k < 400 && !tx_done_a; k++) @(negedge clk);
        check("t5_b2b_first_done", k < 400, 1'b1);
        tx_data_a = 8'hC3;
        @(negedge clk); tx_start_a = 1'b0;
        check("t5_b2b_restart", tx_busy_a, 1'b1);
        for (k = 0; k < 400 && !tx_done_a; k++) @(negedge clk);
        check("t5_b2b_second_done", k < 400, 1'b1);
        repeat (40) @(negedge clk);
        check("t5_b2b_frames", seen_tx_a - before_tx, 2);

        // Test 5c: reset mid-frame aborts without done pulses
        before_tx = seen_tx_a; before_rx = seen_rx_a;
        tx_data_a = 8'h66; tx_start_a = 1'b1;
        @(negedge clk); tx_start_a = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        check("t5_reset_line", {txd_a, tx_busy_a, tx_done_a, rx_done_a}, 4'b1000);
        repeat (300) @(negedge clk);
        check("t5_reset_no_txdone", seen_tx_a - before_tx, 0);
        check("t5_reset_no_rxdone", seen_rx_a - before_rx, 0);

        // Test 6: 7 data bits, 2 stop bits, loopback 0x5A
        exp_rx_c.push_back(10'h05A); pushed_rx_c++;
        exp_tx_c.push_back(160);     pushed_tx_c++;
        tx_data_c = 7'h5A; tx_start_c = 1'b1;
        @(negedge clk); tx_start_c = 1'b0;
        repeat (220) @(negedge clk);
        // one extra stop bit widens the rx_done->tx_done gap by exactly 16 clk
        check("t6_done_gap", tx_cyc_c - rx_cyc_c, 23);

        repeat (20) @(negedge clk);
        check("rx_a_count", seen_rx_a, pushed_rx_a);
        check("rx_b_count", seen_rx_b, pushed_rx_b);
        check("rx_c_count", seen_rx_c, pushed_rx_c);
        check("tx_a_count", seen_tx_a, pushed_tx_a);
        check("tx_b_count", seen_tx_b, pushed_tx_b);
        check("tx_c_count", seen_tx_c, pushed_tx_c);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
